// File: rtl/bram_stream_loader.sv
// bram_stream_loader: takes a valid/ready stream of packed operand words and
// writes three consecutive segments (node, weight, bias) into port A of the
// b0/b1/b2 BRAM banks, each segment num words long, starting at address 0.
module bram_stream_loader #(
    parameter int CNT_BIT  = 31,
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 4096
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    output logic              o_idle,
    output logic              o_write,
    output logic              o_done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    output logic [AWIDTH-1:0] addr_b0,
    output logic              ce_b0,
    output logic              we_b0,
    output logic [DWIDTH-1:0] d_b0,
    output logic [AWIDTH-1:0] addr_b1,
    output logic              ce_b1,
    output logic              we_b1,
    output logic [DWIDTH-1:0] d_b1,
    output logic [AWIDTH-1:0] addr_b2,
    output logic              ce_b2,
    output logic              we_b2,
    output logic [DWIDTH-1:0] d_b2
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_B0 = 3'd1,
        S_LOAD_B1 = 3'd2,
        S_LOAD_B2 = 3'd3,
        S_FLUSH   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t state, next_state;

    logic [CNT_BIT-1:0] num;
    logic [CNT_BIT-1:0] addr_cnt;
    logic [CNT_BIT-1:0] num_clamped;
    logic               hs;
    logic               last_word;
    logic [2:0]         bank_sel;

    // Write-port registers, one set per bank; wr_en drives both ce and we.
    logic [2:0]         wr_en;
    logic [AWIDTH-1:0]  addr_q [3];
    logic [DWIDTH-1:0]  d_q    [3];

    // Clamping the count to the bank depth keeps addr_cnt < MEM_SIZE, so the
    // truncated address never wraps.
    assign num_clamped = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CNT_BIT'(MEM_SIZE) : i_num_cnt;
    assign hs          = s_valid & s_ready;
    assign last_word   = (addr_cnt == (num - CNT_BIT'(1)));
    assign bank_sel    = {state == S_LOAD_B2, state == S_LOAD_B1, state == S_LOAD_B0};

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: segments advance on the handshake of their last word.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_run) begin
                    next_state = (num_clamped == '0) ? S_DONE : S_LOAD_B0;
                end
            end
            S_LOAD_B0: if (hs && last_word) next_state = S_LOAD_B1;
            S_LOAD_B1: if (hs && last_word) next_state = S_LOAD_B2;
            S_LOAD_B2: if (hs && last_word) next_state = S_FLUSH;
            S_FLUSH:   next_state = S_DONE;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Status and stream-ready outputs, decoded from the registered state only.
    always_comb begin
        o_idle  = 1'b0;
        o_write = 1'b0;
        o_done  = 1'b0;
        s_ready = 1'b0;
        case (state)
            S_IDLE:    o_idle = 1'b1;
            S_LOAD_B0,
            S_LOAD_B1,
            S_LOAD_B2: begin
                o_write = 1'b1;
                s_ready = 1'b1;
            end
            S_FLUSH:   o_write = 1'b1;
            S_DONE:    o_done = 1'b1;
            default:   o_idle = 1'b0;
        endcase
    end

    // Word count latch and per-segment address counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num      <= '0;
            addr_cnt <= '0;
        end else if (state == S_IDLE && i_run) begin
            num      <= num_clamped;
            addr_cnt <= '0;
        end else if (hs) begin
            addr_cnt <= last_word ? '0 : addr_cnt + CNT_BIT'(1);
        end
    end

    // Registered bank write port: a handshake in cycle t shows on the bank in t+1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                addr_q[i] <= '0;
                d_q[i]    <= '0;
            end
        end else begin
            wr_en <= hs ? bank_sel : 3'b000;
            for (int i = 0; i < 3; i++) begin
                if (hs && bank_sel[i]) begin
                    addr_q[i] <= addr_cnt[AWIDTH-1:0];
                    d_q[i]    <= s_data;
                end
            end
        end
    end

    assign ce_b0   = wr_en[0];
    assign we_b0   = wr_en[0];
    assign addr_b0 = addr_q[0];
    assign d_b0    = d_q[0];
    assign ce_b1   = wr_en[1];
    assign we_b1   = wr_en[1];
    assign addr_b1 = addr_q[1];
    assign d_b1    = d_q[1];
    assign ce_b2   = wr_en[2];
    assign we_b2   = wr_en[2];
    assign addr_b2 = addr_q[2];
    assign d_b2    = d_q[2];

endmodule
